insn_encoder: RTL and testbench

Inverse of the pd2 decode stage: accepts decoded RISC-V RV32I instruction fields (format, opcode, rd, rs1, rs2, funct3, funct7, imm) over a valid/ready handshake. It re-encodes each instruction into a 32-bit word, buffers the words in a small FIFO, and writes them to instruction memory at sequential addresses from BASE_ADDR. The bench uses it to build program images that the fetch stage then executes. An ECALL ends a program and the block drains and signals done.

---
 rtl/pd_enc_pkg.sv | 59 +++++
 rtl/enc_fifo.sv | 53 +++++
 rtl/insn_encoder.sv | 108 ++++++++++
 tb/tb_insn_encoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pd_enc_pkg.sv
// Shared types and the RV32I field-to-word encoder used by insn_encoder.
// The encoder lives here so a reference model can call the same function.
package pd_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } enc_state_e;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  typedef struct packed {
    logic [31:0] word;
    logic        bad_fmt;  // fmt 6..7: nothing to encode
    logic        bad_imm;  // B/J branch offset with bit 0 set
  } enc_result_t;

  function automatic enc_result_t encode_insn(
    input logic [2:0]  fmt,
    input logic [6:0]  opcode,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  funct3,
    input logic [6:0]  funct7,
    input logic [31:0] imm
  );
    enc_result_t r;
    // NOTE: every field gets a default before the case so no path leaves it unassigned.
    r = '0;
    case (fmt_e'(fmt))
      FMT_R: r.word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: r.word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: r.word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: begin
        r.word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        r.bad_imm = imm[0];
      end
      FMT_U: r.word = {imm[31:12], rd, opcode};
      FMT_J: begin
        r.word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        r.bad_imm = imm[0];
      end
      default: r.bad_fmt = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO with wrap-bit pointers, full/empty flags, a one-entry-left
// flag for drain detection, and a synchronous flush.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             one_left
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign one_left = (level == (AW+1)'(1));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/insn_encoder.sv
// Re-encodes decoded RV32I field bundles into instruction words and writes them
// to sequential memory addresses; an ECALL ends the program and raises done.
module insn_encoder
  import pd_enc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0100_0000),
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_fmt,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [15:0]           insn_count,
  output logic                  done,
  output logic                  err
);

  enc_state_e            state_q;
  logic                  rdy_en_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           count_q;
  logic                  err_q, done_q;

  enc_result_t enc;
  logic        accept, push, wr_fire;
  logic        fifo_full, fifo_empty, fifo_one_left;
  logic [31:0] fifo_data;

  assign enc = encode_insn(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                           in_funct3, in_funct7, in_imm);

  // rdy_en_q keeps in_ready low until the first edge after reset releases.
  assign in_ready = rdy_en_q && (state_q == RUN) && !fifo_full;
  assign accept   = in_valid && in_ready && !restart;
  assign push     = accept && !enc.bad_fmt;
  assign wr_valid = !fifo_empty;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_data  = fifo_empty ? 32'h0 : fifo_data;

  assign wr_addr    = addr_q;
  assign insn_count = count_q;
  assign done       = done_q;
  assign err        = err_q;

  enc_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .flush     (restart),
    .push      (push),
    .push_data (enc.word),
    .pop       (wr_fire),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .one_left  (fifo_one_left)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      rdy_en_q <= 1'b0;
      addr_q   <= BASE_ADDR;
      count_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (restart) begin
        state_q <= RUN;
        addr_q  <= BASE_ADDR;
        count_q <= '0;
        err_q   <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        if (wr_fire) begin
          addr_q <= addr_q + ADDR_WIDTH'(4);
          if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
        end
        if (accept && (enc.bad_fmt || enc.bad_imm)) err_q <= 1'b1;
        case (state_q)
          RUN:   if (push && enc.word == ECALL_WORD) state_q <= DRAIN;
          // No pushes happen in DRAIN, so popping the last entry empties the FIFO.
          DRAIN: if (wr_fire && fifo_one_left) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
          DONE:    ;
          default: state_q <= RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_insn_encoder.sv
// Scoreboard bench for insn_encoder: expected (addr, word) pairs are queued on
// acceptance and compared against every completed memory write.
module tb_insn_encoder;
  import pd_enc_pkg::*;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        reset, restart, in_valid, in_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] insn_count;
  logic        done, err;

  always #5 clk = ~clk;

  insn_encoder dut (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_fmt     (in_fmt),
    .in_opcode  (in_opcode),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_funct7  (in_funct7),
    .in_imm     (in_imm),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .insn_count (insn_count),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] next_addr = BASE;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: handshake values are stable around the falling edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && wr_valid && wr_ready) begin
      check("write_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic push_exp, input logic [31:0] exp_word);
    logic accepted;
    accepted  = 1'b0;
    in_fmt    = fmt;  in_opcode = op;  in_rd  = rd;  in_rs1 = rs1;
    in_rs2    = rs2;  in_funct3 = f3;  in_funct7 = f7;  in_imm = imm;
    in_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      tick();
    end
    if (accepted) begin
      if (push_exp) begin
        sb_q.push_back('{addr: next_addr, data: exp_word});
        next_addr = next_addr + 32'd4;
      end
      tick();
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_addi();
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0050_0093);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200; i++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check("drain_timeout", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart   = 1'b0;
    next_addr = BASE;
    sb_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; wr_ready = 1'b1;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;

    // Reset state
    #12;
    check("rst_wr_valid", wr_valid, 32'd0);
    check("rst_wr_addr", wr_addr, BASE);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_count", insn_count, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_err", err, 32'd0);
    check("rst_in_ready", in_ready, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 32'd1);
    tick();

    // Basic encoding; the S bundle carries a junk rd that must be ignored
    send_addi();
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0020_81B3);
    send(3'd2, 7'h23, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8, 1'b1, 32'h0020_A423);
    wait_drain();
    @(negedge clk);
    check("basic_count", insn_count, 32'd3);
    tick();

    // Immediate scrambling
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b1, 32'hFE20_8CE3);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1, 32'h0100_00EF);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    wait_drain();
    @(negedge clk);
    check("imm_err", err, 32'd0);
    check("imm_count", insn_count, 32'd6);
    tick();

    // Backpressure: four fill the FIFO, the fifth waits for a pop
    do_restart();
    wr_ready = 1'b0;
    send_addi();
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0020_81B3);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020_A423);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b1, 32'hFE20_8CE3);
    in_fmt = 3'd5; in_opcode = 7'h6F; in_rd = 5'd1; in_imm = 32'd16; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 32'd0);
      check("bp_wr_valid", wr_valid, 32'd1);
      check("bp_wr_data", wr_data, 32'h0050_0093);
      check("bp_wr_addr", wr_addr, BASE);
    end
    tick();
    wr_ready = 1'b1;
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1, 32'h0100_00EF);
    wait_drain();
    @(negedge clk);
    check("bp_count", insn_count, 32'd5);
    tick();

    // ECALL termination
    do_restart();
    send_addi();
    send(3'd1, 7'h73, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0000_0073);
    @(negedge clk);
    check("ecall_in_ready", in_ready, 32'd0);
    tick();
    in_fmt = 3'd1; in_opcode = 7'h13; in_rd = 5'd1; in_imm = 32'd5; in_valid = 1'b1;
    wait_drain();
    @(negedge clk);
    check("ecall_done", done, 32'd1);
    check("ecall_wr_valid", wr_valid, 32'd0);
    repeat (4) tick();
    @(negedge clk);
    check("done_in_ready", in_ready, 32'd0);
    check("done_count", insn_count, 32'd2);
    check("done_held", done, 32'd1);
    tick();
    in_valid = 1'b0;

    // Errors, then restart clears them
    do_restart();
    send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'd0);
    @(negedge clk);
    check("badfmt_err", err, 32'd1);
    check("badfmt_no_write", wr_valid, 32'd0);
    tick();
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd5, 1'b1, 32'h0020_8263);
    wait_drain();
    @(negedge clk);
    check("badimm_err", err, 32'd1);
    tick();
    do_restart();
    @(negedge clk);
    check("restart_err", err, 32'd0);
    check("restart_count", insn_count, 32'd0);
    tick();
    send_addi();
    wait_drain();
    @(negedge clk);
    check("restart_write_count", insn_count, 32'd1);
    tick();

    // Reset mid-drain with three words buffered
    do_restart();
    wr_ready = 1'b0;
    send_addi();
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h0020_81B3);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1, 32'h0020_A423);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_wr_valid", wr_valid, 32'd0);
    check("midrst_count", insn_count, 32'd0);
    check("midrst_wr_addr", wr_addr, BASE);
    sb_q.delete();
    next_addr = BASE;
    wr_ready  = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    send_addi();
    wait_drain();
    @(negedge clk);
    check("post_rst_count", insn_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
